// File: rtl/csr_arb_pkg.sv
// Shared definitions for the two-master CSR arbiter.
//   CSR_DATA_W     : width of the cdbus CSR data path.
//   DEFAULT_ADDR_W : default CSR address width.
//   state_e        : access sequencer states (idle, strobe issue, read wait, ack).
package csr_arb_pkg;

  localparam int unsigned CSR_DATA_W     = 8;
  localparam int unsigned DEFAULT_ADDR_W = 5;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDone
  } state_e;

endpackage

// File: rtl/csr_arbiter.sv
// Two-master round-robin arbiter in front of the single cdbus CSR port.
// Each access issues exactly one csr_read or csr_write strobe, since cdbus reads have side
// effects (RX FIFO pop).
//
// Parameters:
//   RD_LAT : cycles from csr_read strobe to valid csr_readdata (0..3).
//   ADDR_W : CSR address width.
// Ports:
//   clk, reset                    : clock, asynchronous active-high reset.
//   mN_address/read/write/writedata : master N request (level-held until ack), N = 0, 1.
//   mN_readdata                   : master N read data, updated only when N is served.
//   mN_ack                        : master N one-cycle completion pulse.
//   csr_address/read/write/writedata, csr_readdata : cdbus CSR port.
//   chip_select                   : high while the slave is being accessed (issue and wait).
//   busy                          : high whenever an access is in flight.
// Build option:
//   CSR_ARB_LOCK_EN adds m0_lock/m1_lock. A granted master holding lock at completion keeps
//   exclusive ownership for its next access, making read-modify-write sequences atomic.
module csr_arbiter
  import csr_arb_pkg::*;
#(
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [CSR_DATA_W-1:0] m0_writedata,
  output logic [CSR_DATA_W-1:0] m0_readdata,
  output logic                  m0_ack,
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [CSR_DATA_W-1:0] m1_writedata,
  output logic [CSR_DATA_W-1:0] m1_readdata,
  output logic                  m1_ack,
`ifdef CSR_ARB_LOCK_EN
  input  logic                  m0_lock,
  input  logic                  m1_lock,
`endif
  output logic [ADDR_W-1:0]     csr_address,
  output logic                  csr_read,
  output logic                  csr_write,
  output logic [CSR_DATA_W-1:0] csr_writedata,
  input  logic [CSR_DATA_W-1:0] csr_readdata,
  output logic                  chip_select,
  output logic                  busy
);

  localparam int unsigned CNT_W = (RD_LAT == 0) ? 1 : $clog2(RD_LAT + 1);

  // Per-master views so the rest of the logic can index by grant.
  logic [1:0]            req;
  logic [1:0]            wr_req;
  logic [ADDR_W-1:0]     addr_in  [2];
  logic [CSR_DATA_W-1:0] wdata_in [2];

  assign req         = {m1_read | m1_write, m0_read | m0_write};
  assign wr_req      = {m1_write, m0_write};
  assign addr_in[0]  = m0_address;
  assign addr_in[1]  = m1_address;
  assign wdata_in[0] = m0_writedata;
  assign wdata_in[1] = m1_writedata;

  state_e                state_q;
  logic                  grant_q;
  logic                  wr_q;
  logic                  rr_last_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [1:0]            ack_q;
  logic [CSR_DATA_W-1:0] rdata_q [2];

  logic lock_hold;
  logic lock_owner;

`ifdef CSR_ARB_LOCK_EN
  logic [1:0] lock_in;
  assign lock_in = {m1_lock, m0_lock};
`else
  assign lock_hold  = 1'b0;
  assign lock_owner = 1'b0;
`endif

  // Grant decision for the IDLE cycle.
  logic gnt_valid;
  logic gnt_idx;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = 1'b0;
    if (lock_hold) begin
      // A locked master is the only one eligible.
      gnt_valid = req[lock_owner];
      gnt_idx   = lock_owner;
    end else if (&req) begin
      gnt_valid = 1'b1;
      gnt_idx   = ~rr_last_q;
    end else if (req[0]) begin
      gnt_valid = 1'b1;
      gnt_idx   = 1'b0;
    end else if (req[1]) begin
      gnt_valid = 1'b1;
      gnt_idx   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      grant_q       <= 1'b0;
      wr_q          <= 1'b0;
      rr_last_q     <= 1'b1;
      cnt_q         <= '0;
      ack_q         <= '0;
      rdata_q[0]    <= '0;
      rdata_q[1]    <= '0;
      csr_address   <= '0;
      csr_writedata <= '0;
      csr_read      <= 1'b0;
      csr_write     <= 1'b0;
      chip_select   <= 1'b0;
      busy          <= 1'b0;
`ifdef CSR_ARB_LOCK_EN
      lock_hold     <= 1'b0;
      lock_owner    <= 1'b0;
`endif
    end else begin
      ack_q <= '0;
      case (state_q)
        StIdle: begin
          if (gnt_valid) begin
            state_q       <= StIssue;
            grant_q       <= gnt_idx;
            // Read and write together is illegal; the write takes precedence.
            wr_q          <= wr_req[gnt_idx];
            csr_address   <= addr_in[gnt_idx];
            csr_writedata <= wdata_in[gnt_idx];
            csr_write     <= wr_req[gnt_idx];
            csr_read      <= ~wr_req[gnt_idx];
            chip_select   <= 1'b1;
            busy          <= 1'b1;
          end
`ifdef CSR_ARB_LOCK_EN
          else if (lock_hold && !lock_in[lock_owner]) begin
            // Owner let go without another access: hand priority to the other master.
            lock_hold <= 1'b0;
            rr_last_q <= lock_owner;
          end
`endif
        end

        StIssue: begin
          csr_read  <= 1'b0;
          csr_write <= 1'b0;
          if (wr_q || (RD_LAT == 0)) begin
            if (!wr_q) rdata_q[grant_q] <= csr_readdata;
            ack_q[grant_q] <= 1'b1;
            chip_select    <= 1'b0;
            state_q        <= StDone;
          end else begin
            cnt_q   <= CNT_W'(RD_LAT - 1);
            state_q <= StWait;
          end
        end

        StWait: begin
          if (cnt_q == '0) begin
            rdata_q[grant_q] <= csr_readdata;
            ack_q[grant_q]   <= 1'b1;
            chip_select      <= 1'b0;
            state_q          <= StDone;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        StDone: begin
          busy    <= 1'b0;
          state_q <= StIdle;
`ifdef CSR_ARB_LOCK_EN
          if (lock_in[grant_q]) begin
            lock_hold  <= 1'b1;
            lock_owner <= grant_q;
          end else begin
            lock_hold <= 1'b0;
            rr_last_q <= grant_q;
          end
`else
          rr_last_q <= grant_q;
`endif
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign m0_ack      = ack_q[0];
  assign m1_ack      = ack_q[1];
  assign m0_readdata = rdata_q[0];
  assign m1_readdata = rdata_q[1];

endmodule

// File: tb/tb_csr_arbiter.sv
// Directed self-checking bench for csr_arbiter. The main instance uses RD_LAT=1; four extra
// instances (RD_LAT 0..3) cover the read-latency sweep. Define CSR_ARB_LOCK_EN to add the
// lock scenario.
module tb_csr_arbiter;

  localparam int unsigned AW = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [AW-1:0] m0_address, m1_address;
  logic          m0_read, m0_write, m1_read, m1_write;
  logic [7:0]    m0_writedata, m1_writedata, m0_readdata, m1_readdata;
  logic          m0_ack, m1_ack;
  logic [AW-1:0] csr_address;
  logic          csr_read, csr_write, chip_select, busy;
  logic [7:0]    csr_writedata, csr_readdata;
`ifdef CSR_ARB_LOCK_EN
  logic          m0_lock, m1_lock;
`endif

  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int ack_cnt = 0;

  csr_arbiter #(.RD_LAT(1), .ADDR_W(AW)) u_dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_readdata(m0_readdata), .m0_ack(m0_ack),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_readdata(m1_readdata), .m1_ack(m1_ack),
`ifdef CSR_ARB_LOCK_EN
    .m0_lock(m0_lock), .m1_lock(m1_lock),
`endif
    .csr_address(csr_address), .csr_read(csr_read), .csr_write(csr_write),
    .csr_writedata(csr_writedata), .csr_readdata(csr_readdata),
    .chip_select(chip_select), .busy(busy)
  );

  // Slave model: data {addr[3:0], ~addr[3:0]} valid only one cycle after the strobe.
  logic rd_d1;
  always @(posedge clk or posedge reset) begin
    if (reset) rd_d1 <= 1'b0;
    else       rd_d1 <= csr_read;
  end
  assign csr_readdata = rd_d1 ? {csr_address[3:0], ~csr_address[3:0]} : 8'hEE;

  always @(posedge clk) begin
    if (csr_read)  rd_cnt <= rd_cnt + 1;
    if (csr_write) wr_cnt <= wr_cnt + 1;
    ack_cnt <= ack_cnt + int'(m0_ack) + int'(m1_ack);
  end

  // Latency sweep instances, one per legal RD_LAT.
  logic          sw_read;
  logic [AW-1:0] sw_addr;
  logic          sw_ack   [4];
  logic [7:0]    sw_rdata [4];

  for (genvar g = 0; g < 4; g++) begin : g_sweep
    logic [AW-1:0] s_addr;
    logic          s_rd, s_wr, s_cs, s_busy, s_ack1;
    logic [7:0]    s_wd, s_rd1, s_rdata;
    logic [3:0]    hist;
    logic [4:0]    taps;

    csr_arbiter #(.RD_LAT(g), .ADDR_W(AW)) u_sw (
      .clk(clk), .reset(reset),
      .m0_address(sw_addr), .m0_read(sw_read), .m0_write(1'b0),
      .m0_writedata(8'h00), .m0_readdata(sw_rdata[g]), .m0_ack(sw_ack[g]),
      .m1_address(5'd0), .m1_read(1'b0), .m1_write(1'b0),
      .m1_writedata(8'h00), .m1_readdata(s_rd1), .m1_ack(s_ack1),
`ifdef CSR_ARB_LOCK_EN
      .m0_lock(1'b0), .m1_lock(1'b0),
`endif
      .csr_address(s_addr), .csr_read(s_rd), .csr_write(s_wr),
      .csr_writedata(s_wd), .csr_readdata(s_rdata),
      .chip_select(s_cs), .busy(s_busy)
    );

    always @(posedge clk or posedge reset) begin
      if (reset) hist <= '0;
      else       hist <= {hist[2:0], s_rd};
    end
    assign taps    = {hist, s_rd};
    assign s_rdata = (taps[g] && s_addr == 5'h1F) ? 8'h81 : 8'hEE;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_address = '0; m0_read = 1'b0; m0_write = 1'b0; m0_writedata = '0;
    m1_address = '0; m1_read = 1'b0; m1_write = 1'b0; m1_writedata = '0;
    sw_read = 1'b0; sw_addr = '0;
`ifdef CSR_ARB_LOCK_EN
    m0_lock = 1'b0; m1_lock = 1'b0;
`endif
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b0;
    #1 reset = 1'b1;
    #2;
    checks++;
    if ({csr_read, csr_write, chip_select, busy, m0_ack, m1_ack} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {csr_read, csr_write, chip_select, busy, m0_ack, m1_ack});
    end
    checks++;
    if ({csr_address, csr_writedata} !== 13'h0) begin
      errors++;
      $display("FAIL reset_csr_bus: got %h expected 0", {csr_address, csr_writedata});
    end
    checks++;
    if ({m0_readdata, m1_readdata} !== 16'h0) begin
      errors++;
      $display("FAIL reset_readdata: got %h expected 0000", {m0_readdata, m1_readdata});
    end
    repeat (2) tick();
    reset = 1'b0;
    repeat (2) tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_single_write();
    int w0;
    w0 = wr_cnt;
    m0_address = 5'h05; m0_writedata = 8'hA5; m0_write = 1'b1;
    tick();  // cycle t+1
    checks++;
    if ({csr_write, csr_read, chip_select} !== 3'b101) begin
      errors++;
      $display("FAIL wr_strobe: got %b expected 101", {csr_write, csr_read, chip_select});
    end
    checks++;
    if (csr_address !== 5'h05 || csr_writedata !== 8'hA5) begin
      errors++;
      $display("FAIL wr_bus: got %h/%h expected 05/a5", csr_address, csr_writedata);
    end
    checks++;
    if (m0_ack !== 1'b0) begin
      errors++;
      $display("FAIL wr_early_ack: got %b expected 0", m0_ack);
    end
    tick();  // cycle t+2
    checks++;
    if ({m0_ack, m1_ack, csr_write, busy} !== 4'b1001) begin
      errors++;
      $display("FAIL wr_ack: got %b expected 1001", {m0_ack, m1_ack, csr_write, busy});
    end
    checks++;
    if (csr_address !== 5'h05 || csr_writedata !== 8'hA5) begin
      errors++;
      $display("FAIL wr_bus_hold: got %h/%h expected 05/a5", csr_address, csr_writedata);
    end
    m0_write = 1'b0;
    tick();
    checks++;
    if ({busy, m0_ack} !== 2'b00) begin
      errors++;
      $display("FAIL wr_idle: got %b expected 00", {busy, m0_ack});
    end
    checks++;
    if (wr_cnt - w0 !== 1) begin
      errors++;
      $display("FAIL wr_strobe_count: got %0d expected 1", wr_cnt - w0);
    end
  endtask

  task automatic test_single_read();
    int r0;
    r0 = rd_cnt;
    m1_address = 5'h03; m1_read = 1'b1;
    tick();  // t+1: strobe
    checks++;
    if ({csr_read, csr_write} !== 2'b10 || csr_address !== 5'h03) begin
      errors++;
      $display("FAIL rd_strobe: got %b addr %h expected 10 addr 03",
               {csr_read, csr_write}, csr_address);
    end
    tick();  // t+2: waiting on slave
    checks++;
    if ({csr_read, chip_select, busy, m1_ack} !== 4'b0110) begin
      errors++;
      $display("FAIL rd_wait: got %b expected 0110", {csr_read, chip_select, busy, m1_ack});
    end
    tick();  // t+3: ack
    checks++;
    if (m1_ack !== 1'b1 || m1_readdata !== 8'h3C) begin
      errors++;
      $display("FAIL rd_ack: got ack %b data %h expected ack 1 data 3c", m1_ack, m1_readdata);
    end
    checks++;
    if (m0_ack !== 1'b0 || m0_readdata !== 8'h00) begin
      errors++;
      $display("FAIL rd_other_master: got ack %b data %h expected 0/00", m0_ack, m0_readdata);
    end
    m1_read = 1'b0;
    tick();
    checks++;
    if (rd_cnt - r0 !== 1) begin
      errors++;
      $display("FAIL rd_strobe_count: got %0d expected 1", rd_cnt - r0);
    end
    checks++;
    if (m1_readdata !== 8'h3C) begin
      errors++;
      $display("FAIL rd_data_held: got %h expected 3c", m1_readdata);
    end
  endtask

  task automatic test_fairness();
    int seq [8];
    int n;
    int last_k;
    do_reset();
    n = 0;
    last_k = 0;
    for (int i = 0; i < 8; i++) seq[i] = -1;
    m0_address = 5'h0A; m0_writedata = 8'h11; m0_write = 1'b1;
    m1_address = 5'h0B; m1_writedata = 8'h22; m1_write = 1'b1;
    for (int k = 1; k <= 60 && n < 8; k++) begin
      tick();
      if (m0_ack) begin seq[n] = 0; n++; last_k = k; end
      else if (m1_ack) begin seq[n] = 1; n++; last_k = k; end
    end
    m0_write = 1'b0;
    m1_write = 1'b0;
    checks++;
    if (n !== 8) begin
      errors++;
      $display("FAIL rr_ack_count: got %0d expected 8", n);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (seq[i] !== i % 2) begin
        errors++;
        $display("FAIL rr_order[%0d]: got %0d expected %0d", i, seq[i], i % 2);
      end
    end
    // First ack two cycles in, then one every three cycles.
    checks++;
    if (last_k !== 23) begin
      errors++;
      $display("FAIL rr_spacing: got last ack cycle %0d expected 23", last_k);
    end
    repeat (3) tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rr_idle: got busy %b expected 0", busy);
    end
  endtask

  task automatic test_reset_mid_read();
    int a0;
    m0_address = 5'h03; m0_read = 1'b1;
    tick();  // ISSUE
    tick();  // WAIT
    checks++;
    if ({chip_select, busy} !== 2'b11) begin
      errors++;
      $display("FAIL mid_pre_reset: got %b expected 11", {chip_select, busy});
    end
    a0 = ack_cnt;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({csr_read, chip_select, busy, m0_ack} !== 4'b0000) begin
      errors++;
      $display("FAIL mid_async_abort: got %b expected 0000",
               {csr_read, chip_select, busy, m0_ack});
    end
    m0_read = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    repeat (3) tick();
    checks++;
    if (ack_cnt !== a0 || m0_readdata !== 8'h00) begin
      errors++;
      $display("FAIL mid_no_ack: got acks %0d data %h expected %0d/00",
               ack_cnt, m0_readdata, a0);
    end
    m0_read = 1'b1;
    repeat (3) tick();
    checks++;
    if (m0_ack !== 1'b1 || m0_readdata !== 8'h3C) begin
      errors++;
      $display("FAIL mid_retry: got ack %b data %h expected 1/3c", m0_ack, m0_readdata);
    end
    m0_read = 1'b0;
    tick();
  endtask

  task automatic test_rd_lat_sweep();
    bit       seen [4];
    int       lat  [4];
    bit [7:0] dat  [4];
    for (int g = 0; g < 4; g++) begin seen[g] = 1'b0; lat[g] = -1; dat[g] = 8'h00; end
    sw_addr = 5'h1F; sw_read = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      for (int g = 0; g < 4; g++) begin
        if (!seen[g] && sw_ack[g]) begin
          seen[g] = 1'b1;
          lat[g]  = k;
          dat[g]  = sw_rdata[g];
        end
      end
    end
    sw_read = 1'b0;
    repeat (8) tick();
    for (int g = 0; g < 4; g++) begin
      checks++;
      if (lat[g] !== 2 + g) begin
        errors++;
        $display("FAIL sweep_lat[RD_LAT=%0d]: got ack cycle %0d expected %0d", g, lat[g], 2 + g);
      end
      checks++;
      if (dat[g] !== 8'h81) begin
        errors++;
        $display("FAIL sweep_data[RD_LAT=%0d]: got %h expected 81", g, dat[g]);
      end
    end
  endtask

`ifdef CSR_ARB_LOCK_EN
  task automatic test_lock();
    int order [3];
    int n;
    int phase;
    do_reset();
    n = 0;
    phase = 0;
    for (int i = 0; i < 3; i++) order[i] = -1;
    m1_address = 5'h08; m1_writedata = 8'h55; m1_write = 1'b1;
    m0_address = 5'h02; m0_lock = 1'b1; m0_read = 1'b1;
    for (int k = 1; k <= 40 && n < 3; k++) begin
      tick();
      if (m0_ack) begin
        order[n] = 0;
        n++;
        if (phase == 0) begin
          m0_read = 1'b0; m0_write = 1'b1; m0_writedata = 8'h99;
          phase = 1;
        end else begin
          m0_write = 1'b0; m0_lock = 1'b0;
        end
      end else if (m1_ack) begin
        order[n] = 1;
        n++;
        m1_write = 1'b0;
      end
    end
    m0_read = 1'b0; m0_write = 1'b0; m0_lock = 1'b0; m1_write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (order[i] !== ((i == 2) ? 1 : 0)) begin
        errors++;
        $display("FAIL lock_order[%0d]: got %0d expected %0d", i, order[i], (i == 2) ? 1 : 0);
      end
    end
    repeat (3) tick();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_fairness();
    test_reset_mid_read();
    test_rd_lat_sweep();
`ifdef CSR_ARB_LOCK_EN
    test_lock();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
